// File: rtl/if_id_reg.sv
// F/D pipeline register: latches PC/instruction, holds on stall, flushes on interrupt,
// flags fetch address errors (AdEL) and delay-slot position. Optional IF_ID_PERF_CNT_EN adds stall/flush counters.
module if_id_reg #(
  parameter logic [31:0] PC_BEGIN    = 32'h0000_3000,
  parameter logic [31:0] PC_END      = 32'h0000_6FFC,
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL    = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_Instr,
  input  logic        Stall,
  input  logic        IntReq,
  input  logic        D_IsBrJmp,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD,
  output logic        D_Valid
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;
  logic        valid_q, valid_d;
  logic        adel;

  // Unsigned compares on the raw 32-bit PC, so addresses near 2^32 never wrap into range.
  assign adel = (F_PC[1:0] != 2'b00) || (F_PC < PC_BEGIN) || (F_PC > PC_END);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    if (IntReq) begin
      pc_d    = EXC_HANDLER;
      instr_d = 32'h0;
      exc_d   = 5'd0;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (!Stall) begin
      pc_d    = F_PC;
      valid_d = 1'b1;
      bd_d    = D_IsBrJmp;
      if (adel) begin
        instr_d = 32'h0;
        exc_d   = EXC_ADEL;
      end else begin
        instr_d = F_Instr;
        exc_d   = 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_BEGIN;
      instr_q <= 32'h0;
      exc_q   <= 5'd0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end

  assign D_PC      = pc_q;
  assign D_Instr   = instr_q;
  assign D_ExcCode = exc_q;
  assign D_BD      = bd_q;
  assign D_Valid   = valid_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall && !IntReq && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (IntReq && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: reset, load, stall hold, AdEL boundaries, BD tagging,
// interrupt flush and reset priority; counters checked when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        Stall;
  logic        IntReq;
  logic        D_IsBrJmp;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;
  logic        D_Valid;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  if_id_reg dut (
    .clk       (clk),
    .reset     (reset),
    .F_PC      (F_PC),
    .F_Instr   (F_Instr),
    .Stall     (Stall),
    .IntReq    (IntReq),
    .D_IsBrJmp (D_IsBrJmp),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .D_ExcCode (D_ExcCode),
    .D_BD      (D_BD),
    .D_Valid   (D_Valid)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full D-stage snapshot: PC, instruction, exception code, BD, valid.
  task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] exc, input logic bd, input logic valid);
    chk({tag, ".pc"}, D_PC, pc);
    chk({tag, ".instr"}, D_Instr, instr);
    chk({tag, ".exc"}, {27'd0, D_ExcCode}, {27'd0, exc});
    chk({tag, ".bd"}, {31'd0, D_BD}, {31'd0, bd});
    chk({tag, ".valid"}, {31'd0, D_Valid}, {31'd0, valid});
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] instr, input logic brj);
    F_PC = pc; F_Instr = instr; D_IsBrJmp = brj;
    tick();
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; IntReq = 1'b0; D_IsBrJmp = 1'b0;
    F_PC = 32'h0000_5000; F_Instr = 32'hDEAD_BEEF;
    tick();
    tick();
    chk_d("reset", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

    reset = 1'b0;
    load(32'h3000, 32'h3C01_0001, 1'b0);
    chk_d("load0", 32'h3000, 32'h3C01_0001, 5'd0, 1'b0, 1'b1);

    Stall = 1'b1;
    load(32'h3004, 32'h1111_1111, 1'b1);
    chk_d("stall1", 32'h3000, 32'h3C01_0001, 5'd0, 1'b0, 1'b1);
    load(32'h3008, 32'h2222_2222, 1'b1);
    chk("stall2.pc", D_PC, 32'h3000);
    load(32'h300C, 32'h8C22_0000, 1'b0);
    chk("stall3.pc", D_PC, 32'h3000);
    Stall = 1'b0;
    load(32'h300C, 32'h8C22_0000, 1'b0);
    chk_d("unstall", 32'h300C, 32'h8C22_0000, 5'd0, 1'b0, 1'b1);

    load(32'h3002, 32'hAAAA_AAAA, 1'b0);
    chk_d("misalign", 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);
    load(32'h7000, 32'hBBBB_BBBB, 1'b0);
    chk_d("pcend+4", 32'h7000, 32'h0, 5'd4, 1'b0, 1'b1);
    load(32'h6FFC, 32'h1234_5678, 1'b0);
    chk_d("pcend", 32'h6FFC, 32'h1234_5678, 5'd0, 1'b0, 1'b1);
    load(32'hFFFF_FFFC, 32'hCCCC_CCCC, 1'b0);
    chk_d("top", 32'hFFFF_FFFC, 32'h0, 5'd4, 1'b0, 1'b1);
    load(32'h2FFC, 32'hDDDD_DDDD, 1'b0);
    chk_d("below", 32'h2FFC, 32'h0, 5'd4, 1'b0, 1'b1);

    // AdEL result must hold across a stall even though F_PC becomes legal.
    Stall = 1'b1;
    load(32'h3000, 32'h0F0F_0F0F, 1'b0);
    chk_d("adelhold", 32'h2FFC, 32'h0, 5'd4, 1'b0, 1'b1);
    Stall = 1'b0;

    load(32'h3010, 32'h0000_0001, 1'b1);
    chk_d("bd1", 32'h3010, 32'h0000_0001, 5'd0, 1'b1, 1'b1);
    load(32'h3014, 32'h0000_0002, 1'b0);
    chk_d("bd0", 32'h3014, 32'h0000_0002, 5'd0, 1'b0, 1'b1);

    load(32'h3001, 32'h0000_0003, 1'b1);
    chk_d("preflush", 32'h3001, 32'h0, 5'd4, 1'b1, 1'b1);
    Stall = 1'b1; IntReq = 1'b1;
    load(32'h3018, 32'h0000_0004, 1'b1);
    chk_d("flush", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);

    reset = 1'b1;
    load(32'h301C, 32'h0000_0005, 1'b1);
    chk_d("rstprio", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

`ifdef IF_ID_PERF_CNT_EN
    chk("cnt.rst.stall", StallCnt, 32'd0);
    chk("cnt.rst.flush", FlushCnt, 32'd0);
    reset = 1'b0; IntReq = 1'b0; Stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    Stall = 1'b0; IntReq = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    IntReq = 1'b0;
    tick();
    chk("cnt.stall", StallCnt, 32'd5);
    chk("cnt.flush", FlushCnt, 32'd2);
    reset = 1'b1;
    tick();
    chk("cnt.clr.stall", StallCnt, 32'd0);
    chk("cnt.clr.flush", FlushCnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
